// File: rtl/modbus_pkg.sv
// Shared constants for the Modbus RTU CRC sequencer and its bit-serial engine.
package modbus_pkg;

    // Sequencer state encoding, kept as plain constants for legacy compatibility
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SHIFT  = 2'd1;
    localparam state_t ST_REPORT = 2'd2;

    // CRC-16/Modbus: x^16+x^15+x^2+1, processed LSB first, so the reflected form is used
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC_RESIDUE   = 16'h0000;
    localparam logic [15:0] CRC_POLY_REFL = 16'hA001;

endpackage

// File: rtl/modbus_crc_ctrl_if.sv
// Byte-stream and result bundle between the frame logic and the CRC sequencer.
interface modbus_crc_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             frame_start;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             frame_end;
    logic             crc_valid;
    logic [15:0]      crc_out;
    logic             crc_ok;
    logic [CNT_W-1:0] byte_cnt;
    logic             busy;

    // Frame logic side: offers bytes and frame delimiters, consumes the result
    modport master (
        output frame_start, byte_valid, byte_data, frame_end,
        input  byte_ready, crc_valid, crc_out, crc_ok, byte_cnt, busy
    );

    // Sequencer side
    modport slave (
        input  frame_start, byte_valid, byte_data, frame_end,
        output byte_ready, crc_valid, crc_out, crc_ok, byte_cnt, busy
    );
endinterface

// File: rtl/crc16.sv
// Bit-serial CRC-16/Modbus engine: one data bit per enabled cycle, LSB first.
module crc16
    import modbus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        xin,
    output logic [15:0] crc
);
    logic [15:0] crc_reg;
    logic [15:0] crc_next;
    logic        fb;

    assign fb = crc_reg[0] ^ xin;

    // Right shift of the reflected register, folding in the polynomial when the feedback bit is set
    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_bit
            assign crc_next[gi] = crc_reg[gi+1] ^ (fb & CRC_POLY_REFL[gi]);
        end
    endgenerate
    assign crc_next[15] = fb & CRC_POLY_REFL[15];

    // CRC register: synchronous reinitialisation wins over shifting
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_reg <= CRC_INIT;
        end else if (ce) begin
            crc_reg <= crc_next;
        end
    end

    assign crc = crc_reg;
endmodule

// File: rtl/modbus_crc_ctrl.sv
// Byte-level sequencer feeding frame bytes LSB-first into the crc16 engine and reporting the result.
module modbus_crc_ctrl
    import modbus_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    modbus_crc_ctrl_if.slave  bus
);
    state_t           state_reg;
    logic [7:0]       sreg_reg;
    logic [2:0]       bit_cnt_reg;
    logic             pend_end_reg;
    logic [CNT_W-1:0] byte_cnt_reg;
    logic             crc_valid_reg;
    logic [15:0]      crc_out_reg;
    logic             crc_ok_reg;

    logic             eng_rst;
    logic             eng_ce;
    logic [15:0]      eng_crc;

    // The engine is held at its init value through reset and re-seeded by every frame_start
    assign eng_rst = ~rst_n | bus.frame_start;
    assign eng_ce  = (state_reg == ST_SHIFT);

    crc16 u_crc16 (
        .clk (clk),
        .rst (eng_rst),
        .ce  (eng_ce),
        .xin (sreg_reg[0]),
        .crc (eng_crc)
    );

    // Sequencer FSM, byte shifter, byte counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            sreg_reg      <= '0;
            bit_cnt_reg   <= '0;
            pend_end_reg  <= 1'b0;
            byte_cnt_reg  <= '0;
            crc_valid_reg <= 1'b0;
            crc_out_reg   <= '0;
            crc_ok_reg    <= 1'b0;
        end else begin
            crc_valid_reg <= 1'b0;
            if (bus.frame_start) begin
                // A new frame aborts whatever is in flight; a byte offered alongside it is taken now
                state_reg    <= ST_IDLE;
                pend_end_reg <= 1'b0;
                byte_cnt_reg <= '0;
                if (state_reg == ST_IDLE && bus.byte_valid) begin
                    sreg_reg     <= bus.byte_data;
                    bit_cnt_reg  <= '0;
                    byte_cnt_reg <= CNT_W'(1);
                    state_reg    <= ST_SHIFT;
                end
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (bus.byte_valid) begin
                            sreg_reg     <= bus.byte_data;
                            bit_cnt_reg  <= '0;
                            pend_end_reg <= bus.frame_end;
                            if (byte_cnt_reg != '1) begin
                                byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
                            end
                            state_reg <= ST_SHIFT;
                        end else if (bus.frame_end) begin
                            state_reg <= ST_REPORT;
                        end
                    end
                    ST_SHIFT: begin
                        sreg_reg    <= {1'b0, sreg_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bus.frame_end) begin
                            pend_end_reg <= 1'b1;
                        end
                        // A frame_end arriving on the final shift still counts for this byte
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= (pend_end_reg | bus.frame_end) ? ST_REPORT : ST_IDLE;
                        end
                    end
                    ST_REPORT: begin
                        crc_out_reg   <= eng_crc;
                        crc_ok_reg    <= (eng_crc == CRC_RESIDUE);
                        crc_valid_reg <= 1'b1;
                        pend_end_reg  <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.byte_ready = (state_reg == ST_IDLE);
    assign bus.busy       = (state_reg != ST_IDLE);
    assign bus.crc_valid  = crc_valid_reg;
    assign bus.crc_out    = crc_out_reg;
    assign bus.crc_ok     = crc_ok_reg;
    assign bus.byte_cnt   = byte_cnt_reg;
endmodule

// File: tb/tb_modbus_crc_ctrl.sv
// Self-checking bench for modbus_crc_ctrl: directed and random frames against a software CRC model.
module tb_modbus_crc_ctrl;
    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_end;

    int n_cmp = 0;
    int n_mis = 0;
    int pulses = 0;
    int cyc = 0;

    modbus_crc_ctrl_if #(.CNT_W(8)) bus8 ();
    modbus_crc_ctrl_if #(.CNT_W(2)) bus2 ();

    assign bus8.frame_start = frame_start;
    assign bus8.byte_valid  = byte_valid;
    assign bus8.byte_data   = byte_data;
    assign bus8.frame_end   = frame_end;
    assign bus2.frame_start = frame_start;
    assign bus2.byte_valid  = byte_valid;
    assign bus2.byte_data   = byte_data;
    assign bus2.frame_end   = frame_end;

    modbus_crc_ctrl #(.CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    modbus_crc_ctrl #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus8.crc_valid) pulses <= pulses + 1;
    end

    // Software CRC-16/Modbus over a whole byte string
    function automatic logic [15:0] model_crc(input logic [7:0] q[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[i]) begin
            c = c ^ {8'h00, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus8.byte_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus8.byte_ready) chk("ready_timeout", 32'(bus8.byte_ready), 32'd1);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe, input logic fs);
        wait_ready();
        byte_valid  = 1'b1;
        byte_data   = b;
        frame_end   = fe;
        frame_start = fs;
        @(negedge clk);
        byte_valid  = 1'b0;
        frame_end   = 1'b0;
        frame_start = 1'b0;
    endtask

    // Called in the cycle where crc_valid is expected high
    task automatic check_result(input string tag, input logic [7:0] q[$]);
        logic [15:0] exp;
        int n;
        exp = model_crc(q);
        n = q.size();
        chk({tag, "_valid"}, 32'(bus8.crc_valid), 32'd1);
        chk({tag, "_crc"}, 32'(bus8.crc_out), 32'(exp));
        chk({tag, "_ok"}, 32'(bus8.crc_ok), 32'(exp == 16'h0000));
        chk({tag, "_cnt"}, 32'(bus8.byte_cnt), 32'(n > 255 ? 255 : n));
        chk({tag, "_crc_w2"}, 32'(bus2.crc_out), 32'(exp));
        chk({tag, "_cnt_w2"}, 32'(bus2.byte_cnt), 32'(n > 3 ? 3 : n));
        $display("frame %s: bytes=%0d crc=%04h ok=%0b cnt=%0d cnt_w2=%0d",
                 tag, n, bus8.crc_out, bus8.crc_ok, bus8.byte_cnt, bus2.byte_cnt);
        @(negedge clk);
        chk({tag, "_pulse_width"}, 32'(bus8.crc_valid), 32'd0);
    endtask

    task automatic end_frame_check(input string tag, input logic [7:0] q[$]);
        wait_ready();
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        chk({tag, "_report_cycle"}, 32'(bus8.crc_valid), 32'd0);
        @(negedge clk);
        check_result(tag, q);
    endtask

    // smode: 0 = separate frame_start, 1 = frame_start with first byte, 2 = none
    task automatic run_frame(input string tag, input logic [7:0] q[$], input logic fe_last, input int smode);
        if (smode == 0) start_frame();
        foreach (q[i]) send_byte(q[i], fe_last && (i == q.size() - 1), (smode == 1) && (i == 0));
        if (fe_last && q.size() > 0) begin
            repeat (8) @(negedge clk);
            chk({tag, "_latency_early"}, 32'(bus8.crc_valid), 32'd0);
            @(negedge clk);
            check_result(tag, q);
        end else begin
            end_frame_check(tag, q);
        end
    endtask

    initial begin
        logic [7:0] tx[$];
        logic [7:0] rx[$];
        logic [7:0] asc[$];
        logic [7:0] q[$];
        logic [7:0] empty[$];
        int p0;
        int prev;
        int acc;
        int low;

        tx  = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        rx  = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
        asc = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        rst_n = 1'b0;
        frame_start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        frame_end = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus8.byte_ready), 32'd1);
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_valid", 32'(bus8.crc_valid), 32'd0);
        chk("rst_crc", 32'(bus8.crc_out), 32'd0);
        chk("rst_cnt", 32'(bus8.byte_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // TX vector
        run_frame("tx", tx, 1'b0, 0);
        chk("tx_const", 32'(bus8.crc_out), 32'h0A84);

        // RX frame with appended CRC, frame_end concurrent with the last byte
        run_frame("rx", rx, 1'b1, 0);
        chk("rx_const_ok", 32'(bus8.crc_ok), 32'd1);

        // Same frame with one random bit flipped
        q = rx;
        q[$urandom_range(0, 7)] ^= 8'(8'h01 << $urandom_range(0, 7));
        run_frame("rx_flip", q, 1'b1, 0);
        chk("rx_flip_bad", 32'(bus8.crc_ok), 32'd0);

        // ASCII check string with byte_valid held high
        start_frame();
        byte_valid = 1'b1;
        byte_data = asc[0];
        prev = 0;
        for (int i = 0; i < 9; i++) begin
            wait_ready();
            acc = cyc;
            @(negedge clk);
            if (i < 8) byte_data = asc[i+1];
            else byte_valid = 1'b0;
            if (i > 0) chk("asc_spacing", 32'(acc - prev), 32'd9);
            prev = acc;
            low = 0;
            while (!bus8.byte_ready && low < 20) begin
                low++;
                @(negedge clk);
            end
            chk("asc_ready_low", 32'(low), 32'd8);
        end
        end_frame_check("ascii", asc);
        chk("ascii_const", 32'(bus8.crc_out), 32'h4B37);

        // Abort: frame_start sampled at the 4th shift edge of a byte
        start_frame();
        p0 = pulses;
        send_byte(8'($urandom), 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        start_frame();
        run_frame("abort", tx, 1'b0, 2);
        chk("abort_const", 32'(bus8.crc_out), 32'h0A84);
        chk("abort_pulses", 32'(pulses - p0), 32'd1);

        // Empty frame
        run_frame("empty", empty, 1'b0, 0);
        chk("empty_const", 32'(bus8.crc_out), 32'hFFFF);

        // Five bytes: narrow counter saturates, CRC unaffected
        q = {};
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
        run_frame("sat5", q, 1'b0, 1);

        // Random frames with random start/end placement
        for (int r = 0; r < 6; r++) begin
            q = {};
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) q.push_back(8'($urandom));
            run_frame($sformatf("rand%0d", r), q, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a shift, then a fresh frame
        start_frame();
        send_byte(8'h5A, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(bus8.byte_ready), 32'd1);
        chk("midrst_busy", 32'(bus8.busy), 32'd0);
        chk("midrst_valid", 32'(bus8.crc_valid), 32'd0);
        chk("midrst_crc", 32'(bus8.crc_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("post_rst", tx, 1'b0, 0);
        chk("post_rst_const", 32'(bus8.crc_out), 32'h0A84);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
